// File: rtl/data_memory.sv
// Word-addressed data memory with a fixed multi-cycle access latency.
// BUSYWAIT stalls the requester from the request cycle through the last ACCESS cycle.
module data_memory #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
);

    localparam int unsigned DEPTH    = 1 << DEPTH_BITS;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q;
    logic [DEPTH_BITS-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  req;
    logic                  commit;
    logic [DEPTH_BITS-1:0] idx;
    logic                  unused_addr;

    assign req    = READ | WRITE;
    assign idx    = ADDRESS[DEPTH_BITS+1:2];
    assign commit = (state_q == ACCESS) && (cnt_q == '0);

    // Byte offset and upper bits are dropped: addresses wrap over the word array.
    assign unused_addr = ^{ADDRESS[31:DEPTH_BITS+2], ADDRESS[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The request is captured once so input churn during ACCESS cannot alter it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && req) begin
            wr_q    <= WRITE;
            idx_q   <= idx;
            wdata_q <= WRITEDATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            if (wr_q) begin
                mem_q[idx_q] <= wdata_q;
            end else begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    assign BUSYWAIT = (state_q == ACCESS) || (state_q == IDLE && req);
    assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus randomized traffic
// checked against an array model of the word memory.
module tb_data_memory;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DB    = 6;
    localparam int unsigned DEPTH = 1 << DB;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        busy;

    logic        rd2, wr2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        busy2;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    data_memory #(.LATENCY(LAT), .DEPTH_BITS(DB)) dut (
        .CLK(clk), .RESET(rst), .READ(rd), .WRITE(wr),
        .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(busy)
    );

    data_memory #(.LATENCY(2), .DEPTH_BITS(DB)) dut2 (
        .CLK(clk), .RESET(rst), .READ(rd2), .WRITE(wr2),
        .ADDRESS(addr2), .WRITEDATA(wdata2), .READDATA(rdata2), .BUSYWAIT(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
        rdata_m = '0;
    endtask

    // churn: 0 none, 1 random inputs during ACCESS, 2 fixed ADDRESS=0x40/WRITEDATA=1
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int churn, input bit hold);
        int n = 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
            if (churn == 1) begin
                addr = $urandom; wdata = $urandom; rd = 1'($urandom); wr = 1'($urandom);
            end else if (churn == 2) begin
                addr = 32'h40; wdata = 32'h1;
            end else if (!hold) begin
                rd = 1'b0; wr = 1'b0;
            end
            #1;
        end
        if (w) mem_m[widx(a)] = d;
        else   rdata_m = mem_m[widx(a)];
        check("busy_cycles", 32'(n), 32'(LAT));
        check("rdata_done", rdata, rdata_m);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        #1;
        check("idle_no_busy", 32'(busy), 32'd0);
        check("rdata_idle", rdata, rdata_m);
    endtask

    task automatic acc2(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int n);
        n = 0;
        @(negedge clk);
        rd2 = r; wr2 = w; addr2 = a; wdata2 = d;
        #1;
        while (busy2 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
        model_clear();
        #3;
        check("reset_rdata", rdata, 32'h0);
        check("reset_busy_idle", 32'(busy), 32'd0);
        rd = 1'b1;
        #1;
        check("reset_busy_req", 32'(busy), 32'd1);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write then read
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b1);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b1);
        check("wr_rd_const", rdata, 32'hDEADBEEF);

        // Wrap and byte offset
        access(1'b0, 1'b1, 32'h104, 32'h12345678, 0, 1'b0);
        access(1'b1, 1'b0, 32'h004, 32'h0, 0, 1'b0);
        check("wrap_read", rdata, 32'h12345678);
        access(1'b1, 1'b0, 32'h107, 32'h0, 0, 1'b1);
        check("offset_read", rdata, 32'h12345678);

        // READ and WRITE together: write only
        access(1'b1, 1'b0, 32'h3C, 32'h0, 0, 1'b1);
        access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 0, 1'b1);
        check("rw_keeps_rdata", rdata, 32'h0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b1);
        check("rw_wrote", rdata, 32'hA5A5A5A5);

        // Input churn during ACCESS
        access(1'b0, 1'b1, 32'h30, 32'h55, 2, 1'b1);
        access(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1);
        check("churn_other_word", rdata, 32'h0);
        access(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b1);
        check("churn_target_word", rdata, 32'h55);

        // Reset on the 3rd busy cycle of a write
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = 32'h08; wdata = 32'h77;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1; wr = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_rdata", rdata, 32'h0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'h08, 32'h0, 0, 1'b1);
        check("abort_no_write", rdata, 32'h0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b1);
        check("reset_cleared_mem", rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic r, w;
            logic [31:0] a;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            a = $urandom;
            if ($urandom_range(3) == 0) a = a & 32'h3F;
            access(r, w, a, $urandom, int'($urandom_range(1)), 1'($urandom));
        end

        // LATENCY=2 instance: DONE edge must not start an access
        acc2(1'b0, 1'b1, 32'h0C, 32'hCAFE0001, n);
        check("l2_write_busy", 32'(n), 32'd2);
        wr2 = 1'b0;
        acc2(1'b0, 1'b1, 32'h10, 32'hCAFE0002, n);
        wr2 = 1'b0;
        acc2(1'b1, 1'b0, 32'h0C, 32'h0, n);
        check("l2_read_busy", 32'(n), 32'd2);
        check("l2_read_data", rdata2, 32'hCAFE0001);
        @(posedge clk);
        #1;
        addr2 = 32'h10;
        #1;
        n = 0;
        while (busy2 && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("l2_b2b_busy", 32'(n), 32'd2);
        check("l2_b2b_data", rdata2, 32'hCAFE0002);
        rd2 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 4: number of cycles BUSYWAIT is high per accepted request, legal range 2..15.
REQ-002 SHALL have parameter DEPTH_BITS, default 6: log2 of the word count (64 words of 32 bits).
REQ-003 SHALL have port CLK, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port READ, input, 1: read request from the CPU data port.
REQ-006 SHALL have port WRITE, input, 1: write request from the CPU data port.
REQ-007 SHALL have port ADDRESS, input, 32: byte address.
REQ-008 SHALL have port WRITEDATA, input, 32: store word.
REQ-009 SHALL have port READDATA, output, 32: registered load word.
REQ-010 SHALL have port BUSYWAIT, output, 1: stall to the requester while an access is pending.

Function
REQ-011 SHALL implement a three-state machine with states IDLE, ACCESS and DONE, plus a 4-bit down-counter cnt.
REQ-012 SHALL drive BUSYWAIT = (state==ACCESS) | (state==IDLE & (READ|WRITE)), combinationally, so the stall is seen in the request cycle itself.
REQ-013 In IDLE, at a rising edge with READ|WRITE high, SHALL latch the op, ADDRESS and WRITEDATA, load cnt<=LATENCY-2, and enter ACCESS.
REQ-014 In ACCESS, SHALL decrement cnt at each edge while cnt!=0.
REQ-015 In ACCESS, at the edge where cnt==0, SHALL commit the latched op and enter DONE.
REQ-016 Latency SHALL be exactly LATENCY cycles of BUSYWAIT high, from the request cycle through the last ACCESS cycle.
REQ-017 In DONE, BUSYWAIT SHALL be 0 and READDATA SHALL hold the committed read word.
REQ-018 DONE SHALL return to IDLE at the next edge unconditionally, ignoring READ/WRITE sampled at that edge (still the old request).
REQ-019 Word index SHALL be ADDRESS[DEPTH_BITS+1:2].
REQ-020 ADDRESS[1:0] SHALL be ignored, since byte/half alignment is done by the CPU controllers.
REQ-021 Upper address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_BITS bytes.
REQ-022 A read commit SHALL update READDATA with mem[index].
REQ-023 READDATA SHALL be otherwise stable, including across write commits and idle cycles.
REQ-024 A write commit SHALL store the latched WRITEDATA into mem[index] and SHALL leave READDATA unchanged.
REQ-025 With READ and WRITE both high, SHALL perform a write only.
REQ-026 Changes on ADDRESS, WRITEDATA, READ or WRITE during ACCESS SHALL NOT affect the pending op, because the latched copies are used.
REQ-027 If READ and WRITE drop during ACCESS, SHALL still complete the op, committing a pending write.
REQ-028 A read of a word in the cycle after a write commit to the same word SHALL return the new data.

Reset
REQ-029 On RESET high, asynchronously and independent of CLK, SHALL force state=IDLE, cnt=0 and READDATA=32'h0, and clear every memory word to 0.
REQ-030 Reset mid-ACCESS SHALL abort the op with no write committed.
REQ-031 While RESET is held, BUSYWAIT SHALL follow REQ-012 in the IDLE state.
REQ-032 After RESET deasserts, the first edge with READ|WRITE high SHALL start a new access.

Verification
REQ-033 Write then read, LATENCY=4: write 0xDEADBEEF to 0x10, then read 0x10.
- BUSYWAIT is high for exactly 4 cycles for each request.
- READDATA=0xDEADBEEF in the read DONE cycle.
REQ-034 Wrap and offset: write 0x12345678 to 0x104, then read 0x004 and 0x107.
- Both reads return 0x12345678.
REQ-035 READ=WRITE=1: address 0x20, WRITEDATA 0xA5A5A5A5, prior READDATA 0x0.
- READDATA stays 0x0.
- A later read of 0x20 returns 0xA5A5A5A5.
REQ-036 Input churn: change ADDRESS to 0x40 and WRITEDATA to 0x1 on the 2nd busy cycle of a write 0x55 to 0x30.
- mem[0x30]=0x55.
- mem[0x40] is unchanged.
REQ-037 Reset mid-access: assert RESET on the 3rd busy cycle of a write 0x77 to 0x08.
- State returns to IDLE.
- A subsequent read of 0x08 returns 0x0.
REQ-038 Back-to-back with LATENCY=2: hold READ high across DONE with a new address presented after the DONE edge.
- The DONE edge starts no access.
- The second request shows 2 busy cycles.
